// File: rtl/uart_port_bridge.sv
// uart_port_bridge: kcpsm3 port-bus bridge to the uart_tx/uart_rx macros.
// Decodes port_id and the strobes, returns a registered in_port word, derives
// en_16_x_baud from a programmable 16-bit divisor, keeps sticky error flags
// and raises a level receive interrupt.
module uart_port_bridge #(
    parameter int unsigned DEFAULT_DIVISOR = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic [7:0] rx_data,
    input  logic       rx_data_present,
    input  logic       rx_full,
    input  logic       rx_half_full,
    input  logic       tx_full,
    input  logic       tx_half_full,
    output logic       write_to_uart,
    output logic       read_from_uart,
    output logic       en_16_x_baud
);

    localparam logic [15:0] DEF_DIV = 16'(DEFAULT_DIVISOR);

    localparam logic [7:0] PORT_STATUS = 8'h00;
    localparam logic [7:0] PORT_DATA   = 8'h01;
    localparam logic [7:0] PORT_DIV_LO = 8'h02;
    localparam logic [7:0] PORT_DIV_HI = 8'h03;

    logic [7:0]  r_in_port;
    logic        r_interrupt;
    logic        r_read_from_uart;
    logic        r_en_16_x_baud;
    logic [15:0] r_count;
    logic [15:0] r_divisor;
    logic [7:0]  r_staged_low;
    logic        r_irq_en;
    logic        r_tx_dropped;
    logic        r_rx_full_seen;

    logic        w_wr_ctrl;
    logic        w_wr_data;
    logic        w_wr_div_lo;
    logic        w_wr_div_hi;
    logic        w_tx_drop;
    logic [15:0] w_limit;
    logic [7:0]  w_rd_data;

    assign w_wr_ctrl   = write_strobe && (port_id == PORT_STATUS);
    assign w_wr_data   = write_strobe && (port_id == PORT_DATA);
    assign w_wr_div_lo = write_strobe && (port_id == PORT_DIV_LO);
    assign w_wr_div_hi = write_strobe && (port_id == PORT_DIV_HI);
    assign w_tx_drop   = w_wr_data && tx_full;

    // A zero divisor behaves as one, so the terminal count never underflows.
    assign w_limit = (r_divisor == 16'd0) ? 16'd0 : (r_divisor - 16'd1);

    assign write_to_uart  = w_wr_data && !tx_full;
    assign in_port        = r_in_port;
    assign interrupt      = r_interrupt;
    assign read_from_uart = r_read_from_uart;
    assign en_16_x_baud   = r_en_16_x_baud;

    // Read-side port mux, sampled into in_port every cycle.
    always_comb begin
        w_rd_data = 8'h00;
        case (port_id)
            PORT_STATUS: w_rd_data = {r_rx_full_seen, r_tx_dropped, r_irq_en, rx_data_present,
                                      rx_full, rx_half_full, tx_full, tx_half_full};
            PORT_DATA:   w_rd_data = rx_data;
            PORT_DIV_LO: w_rd_data = r_divisor[7:0];
            PORT_DIV_HI: w_rd_data = r_divisor[15:8];
            default:     w_rd_data = 8'h00;
        endcase
    end

    // Registered read data, FIFO pop and interrupt request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_port        <= 8'h00;
            r_read_from_uart <= 1'b0;
            r_interrupt      <= 1'b0;
        end else begin
            r_in_port        <= w_rd_data;
            r_read_from_uart <= read_strobe && (port_id == PORT_DATA);
            r_interrupt      <= r_irq_en && rx_data_present;
        end
    end

    // Control register and sticky error flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en       <= 1'b0;
            r_tx_dropped   <= 1'b0;
            r_rx_full_seen <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= out_port[0];
            end
            if (w_tx_drop) begin
                r_tx_dropped <= 1'b1;
            end else if (w_wr_ctrl && out_port[6]) begin
                r_tx_dropped <= 1'b0;
            end
            if (rx_full) begin
                r_rx_full_seen <= 1'b1;
            end else if (w_wr_ctrl && out_port[7]) begin
                r_rx_full_seen <= 1'b0;
            end
        end
    end

    // Divisor staging: low byte is held until the high-byte write commits both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_staged_low <= DEF_DIV[7:0];
            r_divisor    <= DEF_DIV;
        end else begin
            if (w_wr_div_lo) begin
                r_staged_low <= out_port;
            end
            if (w_wr_div_hi) begin
                r_divisor <= {out_port, r_staged_low};
            end
        end
    end

    // Baud x16 enable; a commit restarts the period with no pulse on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= 16'd0;
            r_en_16_x_baud <= 1'b0;
        end else if (w_wr_div_hi) begin
            r_count        <= 16'd0;
            r_en_16_x_baud <= 1'b0;
        end else if (r_count >= w_limit) begin
            r_count        <= 16'd0;
            r_en_16_x_baud <= 1'b1;
        end else begin
            r_count        <= r_count + 16'd1;
            r_en_16_x_baud <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_port_bridge.sv
// Directed bench for uart_port_bridge: inputs change 1 ns after each rising
// edge and outputs are sampled at that same point.
module tb_uart_port_bridge;

    logic       clk;
    logic       rst;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic [7:0] rx_data;
    logic       rx_data_present;
    logic       rx_full;
    logic       rx_half_full;
    logic       tx_full;
    logic       tx_half_full;
    logic       write_to_uart;
    logic       read_from_uart;
    logic       en_16_x_baud;

    int unsigned n_total;
    int unsigned n_pass;

    uart_port_bridge #(.DEFAULT_DIVISOR(26)) dut (
        .clk            (clk),
        .rst            (rst),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .read_strobe    (read_strobe),
        .in_port        (in_port),
        .interrupt      (interrupt),
        .rx_data        (rx_data),
        .rx_data_present(rx_data_present),
        .rx_full        (rx_full),
        .rx_half_full   (rx_half_full),
        .tx_full        (tx_full),
        .tx_half_full   (tx_half_full),
        .write_to_uart  (write_to_uart),
        .read_from_uart (read_from_uart),
        .en_16_x_baud   (en_16_x_baud)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr);
        port_id = addr;
        tick();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        port_id = 8'h05; out_port = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        rx_data = 8'h00; rx_data_present = 1'b0; rx_full = 1'b0; rx_half_full = 1'b0;
        tx_full = 1'b0; tx_half_full = 1'b0;
        #1;
        check("rst_in_port", in_port, 8'h00);
        check("rst_interrupt", {7'd0, interrupt}, 8'h00);
        check("rst_read_from_uart", {7'd0, read_from_uart}, 8'h00);
        check("rst_en_baud", {7'd0, en_16_x_baud}, 8'h00);
        tick(); tick();
        rst = 1'b0;

        // Default divisor 26: pulses on edges 26, 52, 78 after release.
        for (int k = 1; k <= 100; k++) begin
            tick();
            check($sformatf("baud26_edge%0d", k), {7'd0, en_16_x_baud},
                  (k % 26 == 0) ? 8'h01 : 8'h00);
        end
        check("unmapped_port_05", in_port, 8'h00);

        rd(8'h02);
        check("default_div_lo", in_port, 8'h1A);
        rd(8'h03);
        check("default_div_hi", in_port, 8'h00);

        // Divisor 10: staged low byte, commit restarts the period.
        wr(8'h02, 8'h0A);
        rd(8'h02);
        check("stage_no_commit_lo", in_port, 8'h1A);
        wr(8'h03, 8'h00);
        check("commit_edge_no_pulse", {7'd0, en_16_x_baud}, 8'h00);
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) tick();
            else begin port_id = 8'h02; tick(); end
            if (k == 1) check("readback_div_lo", in_port, 8'h0A);
            check($sformatf("baud10_edge%0d", k), {7'd0, en_16_x_baud},
                  (k % 10 == 0) ? 8'h01 : 8'h00);
        end
        rd(8'h03);
        check("readback_div_hi", in_port, 8'h00);

        // Divisor 0 behaves as 1: enable stays high.
        wr(8'h02, 8'h00);
        wr(8'h03, 8'h00);
        check("commit0_edge", {7'd0, en_16_x_baud}, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("baud1_edge%0d", k), {7'd0, en_16_x_baud}, 8'h01);
        end

        // TX write pass-through and drop.
        port_id = 8'h01; out_port = 8'h55; write_strobe = 1'b1; tx_full = 1'b0;
        #1;
        check("tx_write_ok", {7'd0, write_to_uart}, 8'h01);
        tx_full = 1'b1;
        #1;
        check("tx_write_blocked", {7'd0, write_to_uart}, 8'h00);
        tick();
        write_strobe = 1'b0; tx_full = 1'b0;
        rd(8'h00);
        check("status_tx_dropped", in_port, 8'h40);
        wr(8'h00, 8'h40);
        rd(8'h00);
        check("status_tx_cleared", in_port, 8'h00);

        // RX read: byte returned, pop one cycle later for one cycle.
        rx_data = 8'hA5; rx_data_present = 1'b1;
        port_id = 8'h01; read_strobe = 1'b1;
        #1;
        check("pop_not_yet", {7'd0, read_from_uart}, 8'h00);
        tick();
        read_strobe = 1'b0;
        check("rx_data_read", in_port, 8'hA5);
        check("pop_high", {7'd0, read_from_uart}, 8'h01);
        tick();
        check("pop_low", {7'd0, read_from_uart}, 8'h00);

        // Interrupt enable and level behaviour.
        wr(8'h00, 8'h01);
        check("irq_not_yet", {7'd0, interrupt}, 8'h00);
        tick();
        check("irq_high", {7'd0, interrupt}, 8'h01);
        rx_data_present = 1'b0;
        tick();
        check("irq_low", {7'd0, interrupt}, 8'h00);
        rd(8'h00);
        check("status_irq_en", in_port, 8'h20);

        // rx_full_seen: set beats a same-cycle clear.
        rx_full = 1'b1;
        wr(8'h00, 8'h80);
        rx_full = 1'b0;
        rd(8'h00);
        check("rx_full_seen_set_wins", in_port, 8'h80);
        wr(8'h00, 8'h80);
        rd(8'h00);
        check("rx_full_seen_cleared", in_port, 8'h00);

        // Asynchronous reset mid-operation kills a pending pop.
        wr(8'h02, 8'h33);
        wr(8'h03, 8'h00);
        port_id = 8'h01; read_strobe = 1'b1; rx_data = 8'h5A;
        tick();
        read_strobe = 1'b0;
        check("pop_before_rst", {7'd0, read_from_uart}, 8'h01);
        rst = 1'b1;
        #1;
        check("async_rst_pop", {7'd0, read_from_uart}, 8'h00);
        check("async_rst_in_port", in_port, 8'h00);
        tick();
        rst = 1'b0;
        rd(8'h02);
        check("rst_div_lo_restored", in_port, 8'h1A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
